vec_sequencer: RTL

Synthesizable stimulus/response engine for the four-input, two-output combinational example blocks. It drives a fixed table of `{a,b,c,d}` vectors, holding each one for a programmable number of cycles, and samples the DUT outputs `f_b`/`f_nb` at the end of each hold window. It compares both outputs against a built-in expected function and counts mismatches. It sits where the simulation testbench sits today, so the same DUT check runs on the board.

---
 rtl/vec_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vec_sequencer.sv
// vec_sequencer: drives a fixed {a,b,c,d} vector table into a combinational DUT and
// counts f_b/f_nb mismatches at the end of each hold window. Define VEC_SEQ_LOOP_EN to repeat the run.
module vec_sequencer #(
  parameter int unsigned NUM_VEC     = 6,
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_f_b,
  input  logic       i_f_nb,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_vec_idx,
  output logic [3:0] o_err_b,
  output logic [3:0] o_err_nb
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [IDX_W-1:0] r_vec_idx, w_idx_nxt;
  logic [3:0]       r_vec, w_vec_nxt;
  logic [ERR_W-1:0] r_err_b, w_err_b_nxt;
  logic [ERR_W-1:0] r_err_nb, w_err_nb_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_sample, w_last, w_f_exp;

  function automatic logic [3:0] vec_lut(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd1:    vec_lut = 4'b1101;
      3'd2:    vec_lut = 4'b1111;
      3'd3:    vec_lut = 4'b1000;
      3'd4:    vec_lut = 4'b0011;
      3'd5:    vec_lut = 4'b1010;
      default: vec_lut = 4'b0000;
    endcase
  endfunction

  assign w_sample = (r_hold_cnt == LAST_HOLD);
  assign w_last   = (r_vec_idx == LAST_IDX);
  // r_vec always holds table[r_vec_idx] while driving, so it is the vector under test
  assign w_f_exp  = (r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (i_abort) w_state_nxt = S_IDLE;
`ifndef VEC_SEQ_LOOP_EN
        else if (w_sample && w_last) w_state_nxt = S_DONE;
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; abort pre-empts the sample on the same cycle
  always_comb begin
    w_hold_nxt   = '0;
    w_idx_nxt    = '0;
    w_err_b_nxt  = r_err_b;
    w_err_nb_nxt = r_err_nb;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_err_b_nxt  = '0;
          w_err_nb_nxt = '0;
        end
      end
      S_DRIVE: begin
        if (!i_abort) begin
          w_idx_nxt  = r_vec_idx;
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
          if (w_sample) begin
            w_hold_nxt = '0;
            if ((i_f_b != w_f_exp) && (r_err_b != ERR_MAX))
              w_err_b_nxt = r_err_b + ERR_W'(1);
            if ((i_f_nb != w_f_exp) && (r_err_nb != ERR_MAX))
              w_err_nb_nxt = r_err_nb + ERR_W'(1);
            if (w_last) begin
              w_idx_nxt = '0;
`ifdef VEC_SEQ_LOOP_EN
              w_done_nxt = 1'b1;
`endif
            end else begin
              w_idx_nxt = r_vec_idx + IDX_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
    if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
    w_busy_nxt = (w_state_nxt == S_DRIVE);
    w_vec_nxt  = w_busy_nxt ? vec_lut(w_idx_nxt) : 4'b0000;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
      r_vec_idx  <= '0;
      r_vec      <= '0;
      r_err_b    <= '0;
      r_err_nb   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
      r_vec_idx  <= w_idx_nxt;
      r_vec      <= w_vec_nxt;
      r_err_b    <= w_err_b_nxt;
      r_err_nb   <= w_err_nb_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign {o_a, o_b, o_c, o_d} = r_vec;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_vec_idx = r_vec_idx;
  assign o_err_b   = r_err_b;
  assign o_err_nb  = r_err_nb;

endmodule
